// File: rtl/mux_scan_if.sv
// Handshake and Mux-side signals of the scan sequencer.
// master = sequencer side, slave = Mux/downstream side.
interface mux_scan_if;
  logic       start;
  logic       auto_scan;
  logic       mux_out;
  logic [1:0] mux_sel;
  logic [3:0] scan_data;
  logic       scan_valid;
  logic       scan_ready;
  logic       busy;

  modport master (
    input  start, auto_scan, mux_out, scan_ready,
    output mux_sel, scan_data, scan_valid, busy
  );

  modport slave (
    output start, auto_scan, mux_out, scan_ready,
    input  mux_sel, scan_data, scan_valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 Mux select through channels 0..3, samples each after a settle
// delay and offers the assembled 4-bit word on a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start, busy=0
// SETTLE | mux_sel stable, counting settle cycles
// SAMPLE | capture mux_out for current channel
// HOLD   | word offered, waiting for scan_ready
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ch;
  logic [2:0]       shadow;
  logic [1:0]       mux_sel_q;
  logic [3:0]       scan_data_q;
  logic             scan_valid_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ch           <= 2'd0;
      shadow       <= 3'd0;
      mux_sel_q    <= 2'd0;
      scan_data_q  <= 4'd0;
      scan_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SETTLE;
            ch        <= 2'd0;
            mux_sel_q <= 2'd0;
            cnt       <= '0;
            busy_q    <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) state <= SAMPLE;
          else                 cnt   <= cnt + 1'b1;
        end
        SAMPLE: begin
          if (ch != 2'd3) begin
            shadow[ch] <= bus.mux_out;
            ch         <= ch + 2'd1;
            mux_sel_q  <= ch + 2'd1;
            cnt        <= '0;
            state      <= SETTLE;
          end else begin
            // last channel goes straight into the word, no shadow round-trip
            scan_data_q  <= {bus.mux_out, shadow};
            scan_valid_q <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.scan_ready) begin
            scan_valid_q <= 1'b0;
            if (bus.auto_scan) begin
              ch        <= 2'd0;
              mux_sel_q <= 2'd0;
              cnt       <= '0;
              state     <= SETTLE;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mux_sel    = mux_sel_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: default settle (3) and a settle=1 instance.
module tb_mux_scan_sequencer;

  logic clk;
  logic rst_n;
  logic [3:0] mux_in;
  logic [3:0] mux_in1;
  int checks;
  int errors;

  mux_scan_if bus();
  mux_scan_if bus1();

  mux_scan_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master)
  );

  // behavioural 4:1 Mux
  assign bus.mux_out  = mux_in[bus.mux_sel];
  assign bus1.mux_out = mux_in1[bus1.mux_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edges until scan_valid seen on the chosen instance, bounded
  task automatic wait_valid(input bit which, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((which ? bus1.scan_valid : bus.scan_valid) !== 1'b1) && n < 100);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.mux_sel, bus.scan_valid, bus.busy, bus.scan_data} !== 8'h00) begin
      errors++; $display("FAIL reset_values: got %b expected 00000000",
                         {bus.mux_sel, bus.scan_valid, bus.busy, bus.scan_data});
    end
    rst_n = 1'b1;
    tick();
    mux_in = 4'b1010;
    pulse_start();
    repeat (9) tick();
    checks++;
    if (bus.mux_sel !== 2'd2 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_ch2: mux_sel=%0d busy=%b expected 2 1", bus.mux_sel, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mux_sel !== 2'd0 || bus.scan_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_async: mux_sel=%0d valid=%b busy=%b expected 0 0 0",
                         bus.mux_sel, bus.scan_valid, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.scan_valid !== 1'b0 || bus.mux_sel !== 2'd0) begin
      errors++; $display("FAIL reset_idle_after: busy=%b valid=%b mux_sel=%0d expected 0 0 0",
                         bus.busy, bus.scan_valid, bus.mux_sel);
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_sel;
    mux_in = 4'b1010;
    bus.scan_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_sel = (k < 16) ? 2'(k / 4) : 2'd3;
      checks++;
      if (bus.mux_sel !== exp_sel) begin
        errors++; $display("FAIL basic_sel edge %0d: got %0d expected %0d", k, bus.mux_sel, exp_sel);
      end
      checks++;
      if (bus.scan_valid !== (k == 16)) begin
        errors++; $display("FAIL basic_valid edge %0d: got %b expected %b", k, bus.scan_valid, k == 16);
      end
    end
    checks++;
    if (bus.scan_data !== 4'b1010) begin
      errors++; $display("FAIL basic_data: got %b expected 1010", bus.scan_data);
    end
    tick();
    checks++;
    if (bus.scan_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_accept: valid=%b busy=%b expected 0 0", bus.scan_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    mux_in = 4'b0110;
    bus.scan_ready = 1'b0;
    pulse_start();
    wait_valid(1'b0, n);
    checks++;
    if (n != 16 || bus.scan_data !== 4'b0110) begin
      errors++; $display("FAIL bp_first: edges=%0d data=%b expected 16 0110", n, bus.scan_data);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.scan_valid !== 1'b1 || bus.scan_data !== 4'b0110 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid=%b data=%b busy=%b expected 1 0110 1",
                           k, bus.scan_valid, bus.scan_data, bus.busy);
      end
    end
    bus.scan_ready = 1'b1;
    tick();
    checks++;
    if (bus.scan_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: valid=%b busy=%b expected 0 0", bus.scan_valid, bus.busy);
    end
  endtask

  task automatic test_auto();
    int n;
    mux_in = 4'b1111;
    bus.auto_scan = 1'b1;
    bus.scan_ready = 1'b1;
    pulse_start();
    wait_valid(1'b0, n);
    checks++;
    if (n != 16 || bus.scan_data !== 4'b1111) begin
      errors++; $display("FAIL auto_word1: edges=%0d data=%b expected 16 1111", n, bus.scan_data);
    end
    mux_in = 4'b0001;
    tick();
    checks++;
    if (bus.scan_valid !== 1'b0 || bus.busy !== 1'b1 || bus.mux_sel !== 2'd0) begin
      errors++; $display("FAIL auto_restart: valid=%b busy=%b sel=%0d expected 0 1 0",
                         bus.scan_valid, bus.busy, bus.mux_sel);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.scan_valid !== (k == 16)) begin
        errors++; $display("FAIL auto_gap edge %0d: busy=%b valid=%b expected 1 %b",
                           k, bus.busy, bus.scan_valid, k == 16);
      end
    end
    checks++;
    if (bus.scan_data !== 4'b0001) begin
      errors++; $display("FAIL auto_word2: got %b expected 0001", bus.scan_data);
    end
    bus.auto_scan = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.scan_valid !== 1'b0) begin
      errors++; $display("FAIL auto_stop: busy=%b valid=%b expected 0 0", bus.busy, bus.scan_valid);
    end
  endtask

  task automatic test_ignored_start();
    int n;
    mux_in = 4'b1100;
    bus.auto_scan = 1'b0;
    bus.scan_ready = 1'b0;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    n = 5;
    while (bus.scan_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16 || bus.scan_data !== 4'b1100) begin
      errors++; $display("FAIL ign_word: edges=%0d data=%b expected 16 1100", n, bus.scan_data);
    end
    bus.start = 1'b1;
    bus.scan_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.scan_valid !== 1'b0) begin
      errors++; $display("FAIL ign_hold_start: busy=%b valid=%b expected 0 0", bus.busy, bus.scan_valid);
    end
    repeat (20) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.scan_valid !== 1'b0) begin
      errors++; $display("FAIL ign_single_word: busy=%b valid=%b expected 0 0", bus.busy, bus.scan_valid);
    end
  endtask

  task automatic test_settle1();
    int n;
    mux_in1 = 4'b1001;
    bus1.scan_ready = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus1.mux_sel !== 2'd1) begin
      errors++; $display("FAIL s1_sel_edge2: got %0d expected 1", bus1.mux_sel);
    end
    n = 2;
    while (bus1.scan_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8 || bus1.scan_data !== 4'b1001) begin
      errors++; $display("FAIL s1_word: edges=%0d data=%b expected 8 1001", n, bus1.scan_data);
    end
    tick();
    checks++;
    if (bus1.busy !== 1'b0 || bus1.scan_valid !== 1'b0) begin
      errors++; $display("FAIL s1_accept: busy=%b valid=%b expected 0 0", bus1.busy, bus1.scan_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mux_in = 4'b0000;
    mux_in1 = 4'b0000;
    bus.start = 1'b0;
    bus.auto_scan = 1'b0;
    bus.scan_ready = 1'b0;
    bus1.start = 1'b0;
    bus1.auto_scan = 1'b0;
    bus1.scan_ready = 1'b0;
    repeat (2) tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_auto();
    test_ignored_start();
    test_settle1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
